// File: rtl/sl_bus_pkg.sv
// sl_bus_pkg: shared widths and reader state encoding for the slave output bus.
package sl_bus_pkg;
   localparam int SL_ADDR_W = 9;
   localparam int SL_DATA_W = 9;
   localparam int SL_LAST_BIT = 8;
   localparam int SL_IDX_W = 3;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_FETCH,
      ST_SEND,
      ST_RELEASE
   } state_e;
endpackage

// File: rtl/sl_bus_reader_if.sv
// sl_bus_reader_if: shared slave FIFO bus plus the byte stream toward the host.
interface sl_bus_reader_if #(parameter int NUM_SRC = 4);
   import sl_bus_pkg::*;
   logic [NUM_SRC-1:0]   sl_arb_request;
   logic [NUM_SRC-1:0]   sl_arb_grant;
   logic [SL_ADDR_W-1:0] sl_tail;
   logic [SL_ADDR_W-1:0] sl_addr;
   logic [SL_DATA_W-1:0] sl_data;
   logic                 sl_latch_tail;
   logic [7:0]           out_data;
   logic                 out_last;
   logic                 out_valid;
   logic                 out_ready;
   modport master (
      input  sl_arb_request, sl_tail, sl_data, out_ready,
      output sl_arb_grant, sl_addr, sl_latch_tail, out_data, out_last, out_valid
   );
   modport slave (
      output sl_arb_request, sl_tail, sl_data, out_ready,
      input  sl_arb_grant, sl_addr, sl_latch_tail, out_data, out_last, out_valid
   );
endinterface

// File: rtl/sl_bus_reader_arb.sv
// rr_arbiter: round-robin one-hot winner, search starts just past the last retired source.
module rr_arbiter
   import sl_bus_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] req,
   input  logic [NUM_SRC-1:0] gnt,
   input  logic               adv,
   output logic [NUM_SRC-1:0] win
);
   logic [SL_IDX_W-1:0] last_q, last_d;
   logic                found;
   always_comb begin
      win = '0;
      found = 1'b0;
      // offset i from last_q, wrapped without a modulo
      for (int i = 1; i <= NUM_SRC; i++) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            if (!found && req[j] && (int'(last_q) + i == j || int'(last_q) + i == j + NUM_SRC)) begin
               win[j] = 1'b1;
               found = 1'b1;
            end
         end
      end
   end
   always_comb begin
      last_d = last_q;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (adv && gnt[j]) last_d = SL_IDX_W'(j);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= SL_IDX_W'(NUM_SRC - 1);
      else last_q <= last_d;
   end
endmodule

// File: rtl/sl_bus_reader.sv
// sl_bus_reader: grants one FIFO owner at a time and streams its oldest frame byte by byte.
module sl_bus_reader
   import sl_bus_pkg::*;
#(
   parameter int         NUM_SRC   = 4,
   parameter logic [8:0] MAX_FRAME = 9'd300
) (
   input  logic            clk,
   input  logic            rst_n,
   sl_bus_reader_if.master bus,
   output logic            frame_err,
   output logic [15:0]     frame_count
);
   state_e               state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d, win;
   logic [SL_ADDR_W-1:0] addr_q, addr_d;
   logic [8:0]           cnt_q, cnt_d;
   logic [7:0]           data_q, data_d;
   logic                 last_q, last_d, trunc_q, trunc_d, err_q, err_d, adv;
   logic [15:0]          count_q, count_d;
   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .clk(clk),
      .rst_n(rst_n),
      .req(bus.sl_arb_request),
      .gnt(grant_q),
      .adv(adv),
      .win(win)
   );
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d = addr_q;
      cnt_d = cnt_q;
      data_d = data_q;
      last_d = last_q;
      trunc_d = trunc_q;
      err_d = 1'b0;
      count_d = count_q;
      adv = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.sl_arb_request) begin
               grant_d = win;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            addr_d = bus.sl_tail;
            cnt_d = '0;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // the byte at the limit closes the frame even without a last marker
            trunc_d = cnt_q == MAX_FRAME - 9'd1 && !bus.sl_data[SL_LAST_BIT];
            last_d = bus.sl_data[SL_LAST_BIT] || trunc_d;
            data_d = bus.sl_data[7:0];
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (bus.out_ready) begin
               cnt_d = cnt_q + 9'd1;
               addr_d = addr_q + 9'd1;
               err_d = trunc_q;
               state_d = last_q ? ST_RELEASE : ST_FETCH;
            end
         end
         ST_RELEASE: begin
            count_d = count_q + 16'd1;
            adv = 1'b1;
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         addr_q <= '0;
         cnt_q <= '0;
         data_q <= '0;
         last_q <= 1'b0;
         trunc_q <= 1'b0;
         err_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q <= addr_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         last_q <= last_d;
         trunc_q <= trunc_d;
         err_q <= err_d;
         count_q <= count_d;
      end
   end
   assign bus.sl_arb_grant = grant_q;
   assign bus.sl_addr = addr_q;
   assign bus.sl_latch_tail = state_q == ST_RELEASE;
   assign bus.out_data = data_q;
   assign bus.out_last = last_q;
   assign bus.out_valid = state_q == ST_SEND;
   assign frame_err = err_q;
   assign frame_count = count_q;
endmodule

// File: tb/tb_sl_bus_reader.sv
// tb_sl_bus_reader: FIFO-owner model plus frame-level reference for the bus reader.
module tb_sl_bus_reader;
   localparam int NS = 4;
   localparam int MAXF = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_err;
   logic [15:0] frame_count;
   logic [8:0]  mem [NS][512];
   logic [8:0]  tail [NS];
   logic [8:0]  mt [NS];
   logic        tl_set = 1'b0;
   int          tl_src = 0;
   logic [8:0]  tl_val = '0;
   int          gi;
   logic [8:0]  got_q[$], gadr_q[$], lat_q[$], exp_q[$], exp_adr_q[$], exp_lat_q[$];
   int          gseq_q[$];
   int          err_cnt = 0, multi_cnt = 0, chg_cnt = 0, exp_err = 0;
   logic [NS-1:0] prev_g = '0;
   int          n_chk = 0, n_fail = 0;

   sl_bus_reader_if #(.NUM_SRC(NS)) bus();
   sl_bus_reader #(.NUM_SRC(NS), .MAX_FRAME(9'(MAXF))) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .frame_err(frame_err),
      .frame_count(frame_count)
   );
   always #5 clk = ~clk;

   function automatic int oh2i(input logic [NS-1:0] g);
      for (int i = 0; i < NS; i++) if (g[i]) return i;
      return 0;
   endfunction

   function automatic logic [40:0] outs();
      return {bus.sl_arb_grant, bus.sl_addr, bus.sl_latch_tail, bus.out_valid, bus.out_last,
              bus.out_data, frame_err, frame_count};
   endfunction

   always_comb begin
      gi = oh2i(bus.sl_arb_grant);
      bus.sl_tail = |bus.sl_arb_grant ? tail[gi] : '0;
      bus.sl_data = |bus.sl_arb_grant ? mem[gi][bus.sl_addr] : '0;
   end

   always @(posedge clk) begin
      if (tl_set) tail[tl_src] <= tl_val;
      else if (bus.sl_latch_tail) tail[gi] <= bus.sl_addr;
   end

   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_last, bus.out_data});
            gadr_q.push_back(bus.sl_addr);
         end
         if (bus.sl_latch_tail) lat_q.push_back(bus.sl_addr);
         if (frame_err) err_cnt <= err_cnt + 1;
         if ($countones(bus.sl_arb_grant) > 1) multi_cnt <= multi_cnt + 1;
         if (prev_g != 0 && bus.sl_arb_grant != 0 && bus.sl_arb_grant != prev_g) chg_cnt <= chg_cnt + 1;
         if (prev_g == 0 && bus.sl_arb_grant != 0) gseq_q.push_back(oh2i(bus.sl_arb_grant));
      end
      prev_g <= bus.sl_arb_grant;
   end

   // Reference: a frame runs from the tail to its last marker, cut at MAXF bytes.
   function automatic void model(input int s, input logic [8:0] t);
      logic [8:0] a, w;
      a = t;
      for (int k = 0; k < MAXF; k++) begin
         w = mem[s][a];
         exp_q.push_back({w[8] || k == MAXF - 1, w[7:0]});
         exp_adr_q.push_back(a);
         a = a + 9'd1;
         if (w[8]) break;
         if (k == MAXF - 1) exp_err++;
      end
      exp_lat_q.push_back(a);
      mt[s] = a;
   endfunction

   function automatic void clear_exp();
      exp_q.delete();
      exp_adr_q.delete();
      exp_lat_q.delete();
      exp_err = 0;
   endfunction

   task automatic load_frame(input int s, input logic [8:0] t, input int len, input bit mark, input int seq);
      for (int k = 0; k < len; k++) begin
         mem[s][t + 9'(k)] = {mark && k == len - 1, seq >= 0 ? 8'(seq + k) : 8'($urandom)};
      end
   endtask

   task automatic set_tail(input int s, input logic [8:0] v);
      tl_src = s;
      tl_val = v;
      tl_set = 1'b1;
      @(negedge clk);
      tl_set = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_latch(input int n, input bit rnd, output bit ok);
      int seen;
      seen = 0;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (bus.sl_latch_tail) seen++;
         if (seen == n) begin
            ok = 1'b1;
            break;
         end
         if (rnd) bus.out_ready = $urandom_range(3) != 0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (outs() !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h want 0", outs());
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit ok;
      int gs, g0, l0, mc, cc;
      int ord[5] = '{0, 1, 2, 3, 0};
      load_frame(0, 9'h000, 2, 1'b1, -1);
      load_frame(0, 9'h002, 1, 1'b1, -1);
      load_frame(1, 9'h080, 1, 1'b1, -1);
      load_frame(2, 9'h100, 3, 1'b1, -1);
      load_frame(3, 9'h180, 2, 1'b1, -1);
      for (int s = 0; s < NS; s++) begin
         mt[s] = 9'(s * 128);
         set_tail(s, 9'(s * 128));
      end
      clear_exp();
      for (int i = 0; i < 5; i++) model(ord[i], mt[ord[i]]);
      gs = gseq_q.size(); g0 = got_q.size(); l0 = lat_q.size(); mc = multi_cnt; cc = chg_cnt;
      bus.out_ready = 1'b1;
      bus.sl_arb_request = 4'hF;
      wait_latch(5, 1'b0, ok);
      bus.sl_arb_request = '0;
      @(negedge clk);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d latches want 5", lat_q.size() - l0); end
      n_chk++;
      if (gseq_q.size() - gs != 5) begin n_fail++; $display("FAIL rr_grants: got %0d want 5", gseq_q.size() - gs); end
      for (int i = 0; i < 5 && gs + i < gseq_q.size(); i++) begin
         n_chk++;
         if (gseq_q[gs + i] != ord[i]) begin n_fail++; $display("FAIL rr_order%0d: got %0d want %0d", i, gseq_q[gs + i], ord[i]); end
      end
      n_chk++;
      if (multi_cnt != mc || chg_cnt != cc) begin
         n_fail++;
         $display("FAIL rr_grant_onehot_stable: got multi %0d change %0d want 0 0", multi_cnt - mc, chg_cnt - cc);
      end
      n_chk++;
      if (got_q.size() - g0 != exp_q.size()) begin n_fail++; $display("FAIL rr_len: got %0d want %0d", got_q.size() - g0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[g0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_byte%0d: got %h want %h", i, got_q[g0 + i], exp_q[i]); end
      end
      for (int i = 0; i < exp_lat_q.size() && l0 + i < lat_q.size(); i++) begin
         n_chk++;
         if (lat_q[l0 + i] !== exp_lat_q[i]) begin n_fail++; $display("FAIL rr_tail%0d: got %h want %h", i, lat_q[l0 + i], exp_lat_q[i]); end
      end
   endtask

   task automatic test_single();
      bit ok;
      int g0, c0;
      load_frame(0, 9'h010, 3, 1'b1, 8'h41);
      set_tail(0, 9'h010);
      clear_exp();
      model(0, 9'h010);
      g0 = got_q.size(); c0 = int'(frame_count);
      bus.out_ready = 1'b1;
      bus.sl_arb_request = 4'b0001;
      @(negedge clk);
      n_chk++;
      if (bus.sl_arb_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant_n1: got %b want 0001", bus.sl_arb_grant); end
      repeat (2) @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin
         n_fail++;
         $display("FAIL single_first_valid_n3: got v%b %h want v1 41", bus.out_valid, bus.out_data);
      end
      wait_latch(1, 1'b0, ok);
      n_chk++;
      if (!ok || bus.sl_addr !== 9'h013) begin n_fail++; $display("FAIL single_latch: got ok%0d %h want ok1 013", ok, bus.sl_addr); end
      bus.sl_arb_request = '0;
      @(negedge clk);
      n_chk++;
      if (bus.sl_arb_grant !== '0 || frame_count !== 16'(c0 + 1)) begin
         n_fail++;
         $display("FAIL single_release: got grant %b count %0d want 0 %0d", bus.sl_arb_grant, frame_count, c0 + 1);
      end
      n_chk++;
      if (got_q.size() - g0 != 3) begin n_fail++; $display("FAIL single_len: got %0d want 3", got_q.size() - g0); end
      for (int i = 0; i < 3 && g0 + i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[g0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[g0 + i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int g0;
      logic [7:0] d;
      logic l;
      logic [8:0] a;
      load_frame(1, 9'h050, 3, 1'b1, -1);
      set_tail(1, 9'h050);
      clear_exp();
      model(1, 9'h050);
      g0 = got_q.size();
      bus.out_ready = 1'b0;
      bus.sl_arb_request = 4'b0010;
      wait_valid(ok);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      wait_valid(ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL bp_valid_timeout: got no byte 2 want valid"); end
      d = bus.out_data; l = bus.out_last; a = bus.sl_addr;
      n_chk++;
      if (a !== exp_adr_q[1]) begin n_fail++; $display("FAIL bp_addr: got %h want %h", a, exp_adr_q[1]); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_chk++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_last !== l || bus.sl_addr !== a) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v%b %h l%b @%h want v1 %h l%b @%h", c, bus.out_valid, bus.out_data, bus.out_last, bus.sl_addr, d, l, a);
         end
      end
      bus.out_ready = 1'b1;
      wait_latch(1, 1'b0, ok);
      bus.sl_arb_request = '0;
      @(negedge clk);
      n_chk++;
      if (got_q.size() - g0 != exp_q.size()) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", got_q.size() - g0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[g0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[g0 + i], exp_q[i]); end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      int g0, l0, e0;
      load_frame(2, 9'h1FE, 4, 1'b1, -1);
      set_tail(2, 9'h1FE);
      clear_exp();
      model(2, 9'h1FE);
      g0 = got_q.size(); l0 = lat_q.size(); e0 = err_cnt;
      bus.out_ready = 1'b1;
      bus.sl_arb_request = 4'b0100;
      wait_latch(1, 1'b0, ok);
      bus.sl_arb_request = '0;
      @(negedge clk);
      n_chk++;
      if (!ok || lat_q.size() <= l0 || lat_q[l0] !== 9'h002) begin
         n_fail++;
         $display("FAIL wrap_tail: got ok%0d latches %0d want ok1 tail 002", ok, lat_q.size() - l0);
      end
      n_chk++;
      if (got_q.size() - g0 != 4 || err_cnt != e0) begin
         n_fail++;
         $display("FAIL wrap_len_err: got %0d bytes %0d errs want 4 0", got_q.size() - g0, err_cnt - e0);
      end
      for (int i = 0; i < 4 && g0 + i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[g0 + i] !== exp_q[i] || gadr_q[g0 + i] !== exp_adr_q[i]) begin
            n_fail++;
            $display("FAIL wrap_byte%0d: got %h@%h want %h@%h", i, got_q[g0 + i], gadr_q[g0 + i], exp_q[i], exp_adr_q[i]);
         end
      end
   endtask

   task automatic test_truncation();
      bit ok;
      int g0, l0, e0;
      load_frame(3, 9'h100, 6, 1'b0, -1);
      set_tail(3, 9'h100);
      clear_exp();
      model(3, 9'h100);
      g0 = got_q.size(); l0 = lat_q.size(); e0 = err_cnt;
      bus.out_ready = 1'b1;
      bus.sl_arb_request = 4'b1000;
      wait_latch(1, 1'b0, ok);
      bus.sl_arb_request = '0;
      @(negedge clk);
      n_chk++;
      if (!ok || lat_q.size() <= l0 || lat_q[l0] !== 9'h104) begin
         n_fail++;
         $display("FAIL trunc_tail: got ok%0d latches %0d want ok1 tail 104", ok, lat_q.size() - l0);
      end
      n_chk++;
      if (err_cnt - e0 != 1 || exp_err != 1) begin n_fail++; $display("FAIL trunc_err: got %0d pulses want 1", err_cnt - e0); end
      n_chk++;
      if (got_q.size() - g0 != 4) begin n_fail++; $display("FAIL trunc_len: got %0d want 4", got_q.size() - g0); end
      for (int i = 0; i < 4 && g0 + i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[g0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL trunc_byte%0d: got %h want %h", i, got_q[g0 + i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int g0;
      load_frame(0, 9'h020, 3, 1'b1, -1);
      set_tail(0, 9'h020);
      clear_exp();
      model(0, 9'h020);
      bus.out_ready = 1'b0;
      bus.sl_arb_request = 4'b0001;
      wait_valid(ok);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (outs() !== '0) begin n_fail++; $display("FAIL midreset_async: got %h want 0", outs()); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_chk++;
      if (tail[0] !== 9'h020) begin n_fail++; $display("FAIL midreset_tail: got %h want 020", tail[0]); end
      g0 = got_q.size();
      bus.out_ready = 1'b1;
      wait_latch(1, 1'b0, ok);
      bus.sl_arb_request = '0;
      @(negedge clk);
      n_chk++;
      if (!ok || frame_count !== 16'd1) begin n_fail++; $display("FAIL midreset_count: got ok%0d %0d want ok1 1", ok, frame_count); end
      n_chk++;
      if (got_q.size() - g0 != exp_q.size()) begin n_fail++; $display("FAIL midreset_len: got %0d want %0d", got_q.size() - g0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[g0 + i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_byte%0d: got %h want %h", i, got_q[g0 + i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      bit ok;
      int s, len, g0, l0, e0;
      logic [8:0] t;
      for (int it = 0; it < 8; it++) begin
         s = $urandom_range(NS - 1);
         t = 9'($urandom);
         len = $urandom_range(6, 1);
         load_frame(s, t, len, $urandom_range(3) != 0, -1);
         set_tail(s, t);
         clear_exp();
         model(s, t);
         g0 = got_q.size(); l0 = lat_q.size(); e0 = err_cnt;
         bus.sl_arb_request = 4'(1 << s);
         wait_latch(1, 1'b1, ok);
         bus.sl_arb_request = '0;
         bus.out_ready = 1'b1;
         @(negedge clk);
         n_chk++;
         if (!ok || lat_q.size() <= l0 || lat_q[l0] !== exp_lat_q[0] || err_cnt - e0 != exp_err) begin
            n_fail++;
            $display("FAIL rand%0d_tail_err: got ok%0d errs %0d want tail %h errs %0d", it, ok, err_cnt - e0, exp_lat_q[0], exp_err);
         end
         n_chk++;
         if (got_q.size() - g0 != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", it, got_q.size() - g0, exp_q.size()); end
         for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[g0 + i] !== exp_q[i] || gadr_q[g0 + i] !== exp_adr_q[i]) begin
               n_fail++;
               $display("FAIL rand%0d_byte%0d: got %h@%h want %h@%h", it, i, got_q[g0 + i], gadr_q[g0 + i], exp_q[i], exp_adr_q[i]);
            end
         end
      end
   endtask

   initial begin
      for (int s = 0; s < NS; s++) for (int a = 0; a < 512; a++) mem[s][a] = '0;
      bus.sl_arb_request = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_wrap();
      test_truncation();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sl_bus_reader.md
# sl_bus_reader

Drain side of the shared slave output bus: arbitrates among up to NUM_SRC message-FIFO owners that raise `sl_arb_request`, grants one at a time, and reads the granted source's oldest frame byte by byte through `sl_addr`/`sl_tail`/`sl_data`. Each frame is streamed onto a valid/ready byte interface toward the host transmit path (UART/USB packetiser), and `sl_latch_tail` retires it. Sits in the bus controller opposite the per-function interface blocks (basics, I2C, GOC, GPIO, MBus).

## Interface
- NUM_SRC, 4: number of requesting sources, 1..8.
- MAX_FRAME, 9'd300: byte limit per frame before forced termination.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sl_arb_request  input  NUM_SRC  per-source "frame available".
- sl_arb_grant  output  NUM_SRC  one-hot grant; granted source drives the shared lines.
- sl_tail  input  9  granted FIFO's tail (address of first byte of oldest frame).
- sl_addr  output  9  read address into granted FIFO.
- sl_data  input  9  granted FIFO data, one cycle after `sl_addr`; [8] = last byte of frame, [7:0] = byte.
- sl_latch_tail  output  1  one-cycle pulse; granted FIFO sets tail <= `sl_addr`.
- out_data  output  8  streamed byte.
- out_last  output  1  qualifies final byte of frame.
- out_valid  output  1  byte present.
- out_ready  input  1  downstream accepts when high with `out_valid`.
- frame_err  output  1  one-cycle pulse on MAX_FRAME truncation.
- frame_count  output  16  frames retired, wraps.

## Operation
- States: IDLE, GRANT, FETCH, SEND, RELEASE.
- IDLE: if any request, pick winner round-robin starting at index (last_winner+1) mod NUM_SRC. Assert its grant and go to GRANT. After reset, last_winner = NUM_SRC-1, so src0 has first priority.
- GRANT: one settle cycle. Load `sl_addr` <= `sl_tail` and byte_cnt <= 0, then go to FETCH.
- FETCH: one cycle of read latency, then go to SEND. Capture `sl_data` into out_data/out_last.
- SEND: hold `out_valid` until `out_ready`. On accept:
  - Increment byte_cnt.
  - Increment `sl_addr` mod 512 (511 -> 0).
  - If out_last, go to RELEASE. Otherwise go to FETCH.
- Forced termination: if byte_cnt reaches MAX_FRAME-1 on the byte being loaded, force out_last=1 and pulse frame_err when that byte is accepted. Remaining FIFO bytes of that frame are discarded by the tail latch.
- RELEASE: pulse `sl_latch_tail` with `sl_addr` = address after the last byte read. Increment frame_count, record last_winner, drop grant, return to IDLE.
- Grant stays constant from GRANT through RELEASE inclusive. Request changes from the granted source are ignored mid-frame. Other sources wait.
- A source that drops its request before being granted loses nothing. Arbitration re-evaluates every IDLE cycle.
- `out_data`/`out_last` hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: sl_arb_grant=0, sl_addr=0, sl_latch_tail=0, out_valid=0, out_last=0, out_data=0, frame_err=0, frame_count=0, state IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately. The frame is not retired, so the source re-presents it after reset.
- Request in IDLE at cycle n: grant at n+1, first `out_valid` at n+3.
- Throughput with `out_ready` held high: one byte per 2 cycles.
- End of frame: last byte accepted at cycle m, then `sl_latch_tail` at m+1, then grant low and IDLE at m+2. The next grant can occur at m+3.
- Single-byte frame: GRANT, FETCH, SEND, RELEASE. Minimum 5 cycles request-to-idle.
- No combinational path from `out_ready` to `out_valid`/`out_data`.

## Structure
- Shared package `sl_bus_pkg`: SL_ADDR_W=9, SL_DATA_W=9, SL_LAST_BIT=8, and the state encoding.
- One sub-module: `rr_arbiter` (NUM_SRC, request vector, advance pulse -> one-hot winner, rotating pointer). The reader FSM, address counter and output register live in `sl_bus_reader`.

## Test plan
- Single source, 3-byte frame 0x41,0x42,0x43(last) at tail 0x010, `out_ready`=1:
  - Bytes out in order, out_last on 0x43.
  - `sl_latch_tail` with `sl_addr`=0x013.
  - frame_count=1.
- Backpressure: `out_ready` low 5 cycles on byte 2. out_data/out_last are stable and `sl_addr` is unchanged; no byte lost or duplicated.
- Round-robin: src0..src3 all requesting continuously, one frame each.
  - Grant order is 0,1,2,3,0.
  - Grant is never multi-hot and never changes mid-frame.
- Wrap: frame at tail 0x1FE, 4 bytes. Addresses read are 0x1FE, 0x1FF, 0x000, 0x001, and the tail latch occurs at 0x002.
- Truncation: MAX_FRAME=4 with a frame lacking a last marker.
  - 4 bytes out, 4th with out_last.
  - frame_err pulses once and the tail latches at start+4.
- Reset mid-SEND: rst_n low for 2 cycles. All outputs reach reset values asynchronously. After release, the same frame restarts from byte 0 at the unchanged tail.
